exp5_fluxo_dados: RTL

Datapath for the experiment-5 sequence-memory game, directly upstream of the game control unit. It holds the position counter (E), round-limit counter (L), play register (R), fixed sequence ROM, play-timeout timer and button edge detector. It produces every status signal the control unit consumes: `jogada`, `igualE`, `fimE`, `igualL`, `fimL`, `timeout`. It executes the control unit's Moore commands.

---
 rtl/exp5_pkg.sv | 20 ++
 rtl/exp5_contador_m.sv | 44 ++++
 rtl/exp5_fluxo_dados.sv | 134 +++++++++++++
 3 files changed

// File: rtl/exp5_pkg.sv
// exp5_pkg: shared constants for the experiment-5 sequence-memory datapath.
//   LARGURA_DADO          width of button / play / ROM words
//   LARGURA_CONTADOR      width of the E and L position counters
//   TIMEOUT_CICLOS_PADRAO default play timeout in clock cycles (5 s at 1 kHz)
//   ROM_CONTEUDO          fixed game sequence, one-hot words, entry i at [i]
package exp5_pkg;

    localparam int LARGURA_DADO          = 4;
    localparam int LARGURA_CONTADOR      = 4;
    localparam int TIMEOUT_CICLOS_PADRAO = 5000;

    // Listed from address 15 down to address 0 so that ROM_CONTEUDO[a]
    // returns the word at address a.
    // Address order 0..15: 1,2,4,8,4,2,1,1,2,2,4,4,8,8,1,4
    localparam logic [15:0][LARGURA_DADO-1:0] ROM_CONTEUDO = {
        4'h4, 4'h1, 4'h8, 4'h8, 4'h4, 4'h4, 4'h2, 4'h2,
        4'h1, 4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1
    };

endpackage

// File: rtl/exp5_contador_m.sv
// exp5_contador_m: mod-M up counter.
//   clock, reset_n : rising-edge clock, asynchronous active-low reset
//   zera_i         : synchronous clear, wins over conta_i
//   conta_i        : increment; M-1 wraps to 0
//   valor_o        : current count
//   fim_o          : count == M-1
module exp5_contador_m #(
    parameter int M = 16,
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         zera_i,
    input  logic         conta_i,
    output logic [W-1:0] valor_o,
    output logic         fim_o
);

    localparam logic [W-1:0] MAXIMO = W'(M - 1);

    logic [W-1:0] valor_q;
    logic [W-1:0] valor_d;

    always_comb begin
        valor_d = valor_q;
        if (zera_i) begin
            valor_d = '0;
        end else if (conta_i) begin
            valor_d = (valor_q == MAXIMO) ? '0 : valor_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valor_q <= '0;
        end else begin
            valor_q <= valor_d;
        end
    end

    assign valor_o = valor_q;
    assign fim_o   = (valor_q == MAXIMO);

endmodule

// File: rtl/exp5_fluxo_dados.sv
// exp5_fluxo_dados: datapath of the experiment-5 sequence-memory game.
// Executes the control unit's commands and produces its status signals.
//   clock, reset_n      : rising-edge clock, asynchronous active-low reset
//   zeraE/contaE        : clear / increment position counter E
//   zeraL/contaL        : clear / increment round-limit counter L
//   zeraR/registraR     : clear / load play register R from botoes
//   contaT              : run the play timer (timer clears while low)
//   botoes              : player buttons, one-hot when pressed
//   jogada              : one-cycle pulse on a new press
//   igualE              : ROM[E] == R
//   fimE / fimL         : E == N-1 / L == N-1
//   igualL              : E == L
//   timeout             : timer expired (held while contaT stays high)
//   db_contagem, db_limite, db_memoria, db_jogada : E, L, ROM[E], R
module exp5_fluxo_dados
    import exp5_pkg::*;
#(
    parameter int N              = 16,
    parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_PADRAO
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        zeraE,
    input  logic                        contaE,
    input  logic                        zeraL,
    input  logic                        contaL,
    input  logic                        zeraR,
    input  logic                        registraR,
    input  logic                        contaT,
    input  logic [LARGURA_DADO-1:0]     botoes,
    output logic                        jogada,
    output logic                        igualE,
    output logic                        fimE,
    output logic                        igualL,
    output logic                        fimL,
    output logic                        timeout,
    output logic [LARGURA_CONTADOR-1:0] db_contagem,
    output logic [LARGURA_CONTADOR-1:0] db_limite,
    output logic [LARGURA_DADO-1:0]     db_memoria,
    output logic [LARGURA_DADO-1:0]     db_jogada
);

    // Timer is at least 13 bits wide; grows only for very long timeouts.
    localparam int LARGURA_T = ($clog2(TIMEOUT_CICLOS) > 13) ? $clog2(TIMEOUT_CICLOS) : 13;
    localparam logic [LARGURA_T-1:0] T_MAX = LARGURA_T'(TIMEOUT_CICLOS - 1);

    logic [LARGURA_CONTADOR-1:0] contagem_e;
    logic [LARGURA_CONTADOR-1:0] contagem_l;
    logic [LARGURA_DADO-1:0]     memoria;

    logic [LARGURA_DADO-1:0]     r_q;
    logic [LARGURA_DADO-1:0]     r_d;
    logic [LARGURA_T-1:0]        t_q;
    logic [LARGURA_T-1:0]        t_d;
    logic                        s0_q;
    logic                        s0_d;
    logic                        s1_q;
    logic                        s1_d;

    // ---------------- counters E and L ----------------
    exp5_contador_m #(
        .M (N),
        .W (LARGURA_CONTADOR)
    ) u_contador_e (
        .clock   (clock),
        .reset_n (reset_n),
        .zera_i  (zeraE),
        .conta_i (contaE),
        .valor_o (contagem_e),
        .fim_o   (fimE)
    );

    exp5_contador_m #(
        .M (N),
        .W (LARGURA_CONTADOR)
    ) u_contador_l (
        .clock   (clock),
        .reset_n (reset_n),
        .zera_i  (zeraL),
        .conta_i (contaL),
        .valor_o (contagem_l),
        .fim_o   (fimL)
    );

    // ---------------- next-state logic ----------------
    always_comb begin
        r_d = r_q;
        if (zeraR) begin
            r_d = '0;
        end else if (registraR) begin
            r_d = botoes;
        end

        // Saturating timer: parks at T_MAX so timeout stays asserted.
        t_d = t_q;
        if (!contaT) begin
            t_d = '0;
        end else if (t_q != T_MAX) begin
            t_d = t_q + 1'b1;
        end

        s0_d = |botoes;
        s1_d = s0_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_q  <= '0;
            t_q  <= '0;
            s0_q <= 1'b0;
            s1_q <= 1'b0;
        end else begin
            r_q  <= r_d;
            t_q  <= t_d;
            s0_q <= s0_d;
            s1_q <= s1_d;
        end
    end

    // ---------------- status outputs ----------------
    assign memoria = ROM_CONTEUDO[contagem_e];
    assign igualE  = (memoria == r_q);
    assign igualL  = (contagem_e == contagem_l);
    // Gating with contaT makes timeout fall in the same cycle contaT drops.
    assign timeout = contaT && (t_q == T_MAX);
    // Rising edge of "any button pressed": one pulse per press.
    assign jogada  = s0_q & ~s1_q;

    assign db_contagem = contagem_e;
    assign db_limite   = contagem_l;
    assign db_memoria  = memoria;
    assign db_jogada   = r_q;

endmodule
